// File: rtl/vdp_super_res_writer.sv
// Write-side packer for the super-res VRAM path: gathers CPU pixel bytes into
// 32-bit words with byte enables and commits them while the display fetcher is off the bus.
module vdp_super_res_writer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        addr_load,
    input  logic [19:0] addr_in,
    input  logic        pixel_wr,
    input  logic [7:0]  pixel_data,
    input  logic        flush,
    output logic        pixel_ready,
    input  logic        super_res_drawing,
    output logic        vram_wr_req,
    output logic [17:0] vram_wr_addr,
    output logic [31:0] vram_wr_data,
    output logic [3:0]  vram_wr_be,
    input  logic        vram_wr_ack,
    output logic [2:0]  fifo_level,
    output logic        writer_idle,
    output logic        bus_state
);

    // Handshake: vram_wr_req rises with addr/data/be and all four hold until
    // a single-cycle vram_wr_ack is sampled; the entry is popped on that edge.

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [2:0] DEPTH_L = 3'(FIFO_DEPTH);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} bus_state_t;

    bus_state_t state_q, state_d;

    logic [19:0] cur_addr, cur_addr_d;
    logic [31:0] acc_data, acc_data_d, merged_data, push_data;
    logic [3:0]  acc_be, acc_be_d, merged_be, push_be;
    logic [1:0]  lane;
    logic        push, pop, load_head;

    logic [17:0] mem_addr [FIFO_DEPTH];
    logic [31:0] mem_data [FIFO_DEPTH];
    logic [3:0]  mem_be   [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [2:0]  level;

    assign pixel_ready = (level < DEPTH_L);
    assign fifo_level  = level;
    assign bus_state   = state_q;
    assign lane        = cur_addr[1:0];
    assign pop         = (state_q == REQ) && vram_wr_ack;

    always_comb begin
        merged_data = acc_data;
        merged_be   = acc_be;
        cur_addr_d  = cur_addr;
        acc_data_d  = acc_data;
        acc_be_d    = acc_be;
        push        = 1'b0;
        push_data   = acc_data;
        push_be     = acc_be;
        if (pixel_ready) begin
            if (addr_load) begin
                // The pending partial word belongs to the old address, so it leaves first.
                push       = (acc_be != 4'd0);
                cur_addr_d = addr_in;
                acc_data_d = 32'd0;
                acc_be_d   = 4'd0;
            end else begin
                if (pixel_wr) begin
                    merged_data[{lane, 3'b000} +: 8] = pixel_data;
                    merged_be[lane] = 1'b1;
                    cur_addr_d      = cur_addr + 20'd1;
                end
                push      = (pixel_wr && (lane == 2'd3)) || (flush && (merged_be != 4'd0));
                push_data = merged_data;
                push_be   = merged_be;
                if (push) begin
                    acc_data_d = 32'd0;
                    acc_be_d   = 4'd0;
                end else begin
                    acc_data_d = merged_data;
                    acc_be_d   = merged_be;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_addr <= 20'd0;
            acc_data <= 32'd0;
            acc_be   <= 4'd0;
        end else begin
            cur_addr <= cur_addr_d;
            acc_data <= acc_data_d;
            acc_be   <= acc_be_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= cur_addr[19:2];
            mem_data[wr_ptr] <= push_data;
            mem_be[wr_ptr]   <= push_be;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + 3'd1;
                2'b01:   level <= level - 3'd1;
                default: level <= level;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        load_head = 1'b0;
        case (state_q)
            IDLE: begin
                if ((level != 3'd0) && !super_res_drawing) begin
                    load_head = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                // Display reclaiming the bus does not withdraw an issued request.
                if (vram_wr_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            vram_wr_req  <= 1'b0;
            vram_wr_addr <= 18'd0;
            vram_wr_data <= 32'd0;
            vram_wr_be   <= 4'd0;
            writer_idle  <= 1'b1;
        end else begin
            state_q     <= state_d;
            vram_wr_req <= (state_d == REQ);
            if (load_head) begin
                vram_wr_addr <= mem_addr[rd_ptr];
                vram_wr_data <= mem_data[rd_ptr];
                vram_wr_be   <= mem_be[rd_ptr];
            end
            writer_idle <= (level == 3'd0) && (acc_be == 4'd0) && (state_q == IDLE);
        end
    end

endmodule

// File: doc/vdp_super_res_writer.md
# vdp_super_res_writer

Write-side companion to the super-res display fetcher: accepts single pixel bytes from the CPU/command port, packs them into 32-bit VRAM words with byte enables, buffers up to four words, and commits them to SDRAM only while the display fetcher has released the bus (`super_res_drawing == 0`). It sits between the VDP register/port decoder and the VRAM bus arbiter. It uses the same word addressing (18-bit word address, 4 pixels per word, pixel 0 in bits [7:0]) that the super-res display path reads.

## Interface
- `FIFO_DEPTH`, 4, number of buffered word entries (power of two, ≥2).
- `clk` in 1 — VDP clock.
- `reset_n` in 1 — asynchronous, active-low reset.
- `addr_load` in 1 — pulse; load the byte address register from `addr_in`.
- `addr_in` in 20 — pixel byte address; word = [19:2], lane = [1:0].
- `pixel_wr` in 1 — pulse; write `pixel_data` at the current address, then post-increment.
- `pixel_data` in 8 — palette index to write.
- `flush` in 1 — pulse; push any partially filled word.
- `pixel_ready` out 1 — high when the FIFO has at least one free entry. Strobes are only accepted while high.
- `super_res_drawing` in 1 — high while the display fetcher owns VRAM.
- `vram_wr_req` out 1 — write request, held until acknowledged.
- `vram_wr_addr` out 18 — word address.
- `vram_wr_data` out 32 — word data; lane n is in bits [8n+7:8n].
- `vram_wr_be` out 4 — byte enables.
- `vram_wr_ack` in 1 — one-cycle acknowledge from the arbiter.
- `fifo_level` out 3 — current number of FIFO entries.
- `writer_idle` out 1 — high when the FIFO is empty, no partial word is held, and the bus FSM is IDLE.

## Operation
- **Packer state.** `cur_addr[19:0]`, `acc_data[31:0]`, `acc_be[3:0]`.
- **Strobes when `pixel_ready == 0`.** All strobes are ignored (no state change).
- **Pixel write** (`pixel_wr`, `addr_load` low):
  - `acc_data` lane `cur_addr[1:0]` ← `pixel_data`.
  - The matching `acc_be` bit is set.
  - `cur_addr` ← `cur_addr + 1`, modulo 2^20.
  - If the written lane is 3, push {`cur_addr[19:2]`, merged data, merged be} and clear `acc_be`/`acc_data` in the same cycle.
- **Address load** (`addr_load`):
  - If `acc_be != 0`, push the partial word first (same cycle).
  - Then `cur_addr` ← `addr_in`, and `acc` is cleared.
  - `pixel_wr` and `flush` are ignored in this cycle.
- **Flush** (`flush`, no `addr_load`):
  - If `acc_be != 0`, push and clear.
  - If `acc_be == 0`, no-op.
  - `flush` together with `pixel_wr`: the pixel is merged first, then a single push occurs. The lane-3 rule is subsumed, so only one entry is pushed.
- **Byte enables.** Lanes not written retain `acc_be = 0`. Their `acc_data` is 0 and is don't-care in VRAM.
- **Bus FSM:**
  - **IDLE:** if `fifo_level != 0` and `super_res_drawing == 0`, drive the head entry onto `vram_wr_*`, set `vram_wr_req`, and go to REQ.
  - **REQ:** hold `req`/`addr`/`data`/`be` stable. On `vram_wr_ack`, drop `req`, pop the head, and go to IDLE.
  - `super_res_drawing` rising while in REQ does not withdraw the request. New requests are not started while it is high.
  - `vram_wr_ack` while in IDLE is ignored.
- **Simultaneous push and pop.** `fifo_level` is unchanged. FIFO pointers wrap modulo `FIFO_DEPTH`.
- **Reset.** Asynchronous reset mid-transaction discards the FIFO contents and any partial word.

## Timing
- **Reset values:**
  - `vram_wr_req` 0; `vram_wr_addr` 0; `vram_wr_data` 0; `vram_wr_be` 0.
  - `fifo_level` 0; `pixel_ready` 1; `writer_idle` 1.
  - `cur_addr` 0; `acc` 0; FSM in IDLE.
- **`pixel_ready`** = (`fifo_level < FIFO_DEPTH`), decoded from registered level. A pop in cycle N raises it in N+1.
- **Push latency.** A push strobed at edge N is visible in `fifo_level` after edge N.
- **Request latency.** If the FSM is IDLE and the bus is free, `vram_wr_req` rises after edge N+1, a 2-cycle strobe-to-request latency.
- **Acknowledge.** Ack sampled at edge M: `vram_wr_req` is low after M. The earliest next request is after M+1, giving one idle cycle between requests.
- **Bus-free gating.** `super_res_drawing` is sampled at the IDLE decision edge only.
- **`writer_idle`** is registered and updates in the cycle after the conditions change.

## Test plan
1. **Aligned word.** Reset, `addr_load` 0x00010, four `pixel_wr` of 0x11, 0x22, 0x33, 0x44 with `super_res_drawing` = 0 → one request: addr 0x00004, data 0x44332211, be 0xF, two cycles after the 4th strobe. Ack → `req` low next cycle, `writer_idle` = 1.
2. **Partial words.** `addr_load` 0x00006, `pixel_wr` 0xAA, `pixel_wr` 0xBB, `flush` → entry addr 0x00001, data 0xBBAA0000, be 0xC. Then `addr_load` with pending lane 0 only → push with be 0x1 before the new address applies.
3. **Bus held by display.** Hold `super_res_drawing` = 1 and write 16 pixels:
   - `fifo_level` reaches 4 and `pixel_ready` drops; further `pixel_wr` are ignored and the data is unchanged.
   - Drop `super_res_drawing` → four requests in order with incrementing addresses, each spaced ≥2 cycles.
4. **Request stability.** Raise `super_res_drawing` while `req` is high → `req`/`addr`/`data` stay stable until ack; no new request until `super_res_drawing` = 0.
5. **Address wrap.** `addr_load` 0xFFFFE, four writes → first push addr 0x3FFFF be 0xC. `cur_addr` wraps to 0x00000; flush → addr 0x00000 be 0x3.
6. **Reset mid-operation.** Assert `reset_n` low with `req` high and 3 entries queued → all outputs at reset values immediately; no stale request after release.
